// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
// Frame layout: start(1), DATA_W data bits LSB first, parity, stop(0).
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    WAIT_LOW = 3'd5
  } rx_state_e;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parity_mode_e;

  localparam parity_mode_e PARITY_MODE = EVEN;

  // Serial bit periods per frame: start + data + parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_w);
    return data_w + 32'd3;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Loadable down-counter producing a one-cycle tick when a loaded interval expires.
// A load value of N-1 yields the tick N cycles after the loading edge.
module bit_tick_gen #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tick
);

  logic [CW-1:0] cnt_r;
  logic          run_r;

  // Count down after a load; a load on the tick edge restarts the interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      run_r <= 1'b0;
    end else if (load) begin
      cnt_r <= load_val;
      run_r <= 1'b1;
    end else if (run_r) begin
      if (cnt_r == '0) begin
        run_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - CW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = run_r && (cnt_r == '0);

endmodule

// File: rtl/serial_frame_rx.sv
// Receiver for framed words on a single registered serial line (idle level 0).
// Samples mid-bit after a half-bit start check; strobes rx_valid once per complete frame.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_par_err,
  output logic              rx_frm_err,
  output logic              busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0]  HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_W - 1);

  function automatic logic par_err_f(input logic [DATA_W-1:0] d, input logic p);
    return (^{d, p}) ^ logic'(PARITY_MODE);
  endfunction

  rx_state_e         state_r;
  logic              si_q_r;
  logic [BCW-1:0]    bit_cnt_r;
  logic [DATA_W-1:0] shift_r;
  logic              par_bit_r;
  logic [DATA_W-1:0] rx_data_r;
  logic              rx_valid_r;
  logic              rx_par_err_r;
  logic              rx_frm_err_r;
  logic              busy_r;
  logic              load_s;
  logic [CW-1:0]     load_val_s;
  logic              tick_s;

  bit_tick_gen #(.CW(CW)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .load_val (load_val_s),
    .tick     (tick_s)
  );

  // Counter reloads must land on the same edge as the state change they time.
  always_comb begin
    load_s     = 1'b0;
    load_val_s = BIT_LOAD;
    case (state_r)
      IDLE: begin
        if (si_q_r) begin
          load_s     = 1'b1;
          load_val_s = HALF_LOAD;
        end else begin
          load_s = 1'b0;
        end
      end
      START: begin
        if (tick_s && si_q_r) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      DATA, PARITY: begin
        if (tick_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      default: load_s = 1'b0;
    endcase
  end

  // Receive FSM with input register, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      si_q_r       <= 1'b0;
      bit_cnt_r    <= '0;
      shift_r      <= '0;
      par_bit_r    <= 1'b0;
      rx_data_r    <= '0;
      rx_valid_r   <= 1'b0;
      rx_par_err_r <= 1'b0;
      rx_frm_err_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      si_q_r     <= serial_in;
      rx_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (si_q_r) begin
            state_r <= START;
            busy_r  <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        START: begin
          if (tick_s) begin
            if (si_q_r) begin
              state_r   <= DATA;
              bit_cnt_r <= '0;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (tick_s) begin
            shift_r[bit_cnt_r] <= si_q_r;
            if (bit_cnt_r == LAST_BIT) begin
              state_r <= PARITY;
            end else begin
              bit_cnt_r <= bit_cnt_r + BCW'(1);
            end
          end
        end
        PARITY: begin
          if (tick_s) begin
            par_bit_r <= si_q_r;
            state_r   <= STOP;
          end
        end
        STOP: begin
          if (tick_s) begin
            rx_data_r    <= shift_r;
            rx_par_err_r <= par_err_f(shift_r, par_bit_r);
            rx_frm_err_r <= si_q_r;
            rx_valid_r   <= 1'b1;
            if (si_q_r) begin
              state_r <= WAIT_LOW;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        WAIT_LOW: begin
          // A line stuck high must not be mistaken for a fresh start bit.
          if (!si_q_r) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data    = rx_data_r;
  assign rx_valid   = rx_valid_r;
  assign rx_par_err = rx_par_err_r;
  assign rx_frm_err = rx_frm_err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed plus randomized bench for serial_frame_rx at DATA_W=8, CLKS_PER_BIT=4.
// Expected strobes come from a frame-level model: data, even-parity rule, stop bit, latency.
module tb_serial_frame_rx;
  import serial_frame_pkg::*;

  localparam int DW  = 8;
  localparam int CPB = 4;
  // Drive edge -> strobe: input register, start detect, half bit, then whole bits to the stop sample.
  localparam int unsigned LAT = 32'd2 + CPB / 2 + (frame_bits(DW) - 32'd1) * CPB;

  typedef struct {
    logic [DW-1:0] d;
    logic          pe;
    logic          fe;
    int unsigned   cyc;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          serial_in = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_par_err;
  logic          rx_frm_err;
  logic          busy;

  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          b2b = 0;
  logic        prev_valid = 1'b0;
  rec_t        exp_q[$];
  rec_t        got_q[$];

  serial_frame_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_par_err (rx_par_err),
    .rx_frm_err (rx_frm_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Record every strobe and flag any two in consecutive cycles.
  always @(negedge clk) begin
    if (rx_valid) begin
      got_q.push_back('{d: rx_data, pe: rx_par_err, fe: rx_frm_err, cyc: cyc});
      if (prev_valid) b2b++;
    end
    prev_valid = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s);
    logic [DW+2:0] bits;
    bits = {s, p, d, 1'b1};
    for (int i = 0; i < DW + 3; i++) begin
      serial_in = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  // Model: even parity means the correct parity bit equals the XOR of the data.
  task automatic send_expect(input logic [DW-1:0] d, input logic p, input logic s);
    exp_q.push_back('{d: d, pe: (^d) ^ p, fe: s, cyc: cyc + LAT});
    send_frame(d, p, s);
  endtask

  task automatic idle(input int n);
    serial_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string tag);
    int n;
    chk({tag, ".count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d].data", tag, i), 32'(got_q[i].d), 32'(exp_q[i].d));
      chk($sformatf("%s[%0d].par_err", tag, i), 32'(got_q[i].pe), 32'(exp_q[i].pe));
      chk($sformatf("%s[%0d].frm_err", tag, i), 32'(got_q[i].fe), 32'(exp_q[i].fe));
      chk($sformatf("%s[%0d].cycle", tag, i), got_q[i].cyc, exp_q[i].cyc);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          p;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset.rx_data", 32'(rx_data), 32'h0);
    chk("reset.rx_valid", 32'(rx_valid), 32'h0);
    chk("reset.flags", 32'({rx_par_err, rx_frm_err}), 32'h0);
    chk("reset.busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    idle(4);

    // One good frame so reset below has something to clear
    d = DW'($urandom_range(1, 255));
    send_expect(d, ^d, 1'b0);
    idle(8);
    check_results("prereset");

    // Reset mid-frame: outputs clear at once, partial frame never strobes
    fork
      send_frame(8'h5A, 1'b0, 1'b0);
      begin
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset.rx_data", 32'(rx_data), 32'h0);
        chk("midreset.busy", 32'(busy), 32'h0);
        chk("midreset.rx_valid", 32'(rx_valid), 32'h0);
      end
    join
    idle(2);
    rst_n = 1'b1;
    idle(60);
    check_results("midreset");

    // Good frame and parity-error frame
    send_expect(8'hA5, 1'b0, 1'b0);
    idle(6);
    check_results("good_a5");
    send_expect(8'h01, 1'b0, 1'b0);
    idle(6);
    check_results("parerr_01");

    // Stop bit 1 with the line held high: single strobe, busy until the line drops
    send_expect(8'h3C, 1'b0, 1'b1);
    repeat (10 * CPB) @(posedge clk);
    #1;
    chk("stuck.busy_high", 32'(busy), 32'h1);
    idle(60);
    check_results("stuck_3c");
    chk("stuck.busy_low", 32'(busy), 32'h0);

    // Single-cycle glitch on an idle line
    serial_in = 1'b1;
    @(posedge clk);
    #1 serial_in = 1'b0;
    @(posedge clk);
    #1;
    chk("glitch.busy_start", 32'(busy), 32'h1);
    idle(8);
    chk("glitch.busy_end", 32'(busy), 32'h0);
    idle(50);
    check_results("glitch");

    // Back-to-back frames with no idle gap
    send_expect(8'hFF, 1'b0, 1'b0);
    send_expect(8'h00, 1'b0, 1'b0);
    idle(8);
    check_results("b2b");

    // Randomized frames, occasional bad parity, random short gaps
    for (int i = 0; i < 12; i++) begin
      d = DW'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      send_expect(d, p, 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(60);
    check_results("random");

    chk("no_adjacent_strobes", 32'(b2b), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
